sysarr_row_buffer: RTL and testbench
====================================

# sysarr_row_buffer

Parametrised multi-bank row staging buffer that feeds one edge lane of the systolic array. It accepts whole matrix rows in parallel (N elements of DW bits) and streams them out one element per shift. It generalises the two-row ping-pong buffer to BANKS row slots and adds a load handshake, occupancy flags, flush, a row-completion pulse and optional error flags. One instance sits per array input lane, between the row loader and the array's input registers.

## Interface
- DW, default sys_arr_pkg::DW: element width in bits.
- N, default sys_arr_pkg::N: elements per row. Must be ≥ 2.
- BANKS, default 2: number of row slots. Must be ≥ 2; need not be a power of two.
- clk  in  1  single clock; everything is on posedge.
- RST  in  1  reset, synchronous, active-high.
- flush  in  1  discard all buffered rows.
- load  in  1  row-load request.
- load_values  in  DW*N  row data; element i = load_values[(N-1-i)*DW +: DW], so element 0 is the MSB slice.
- load_ready  out  1  row slot free; a load is accepted only when load && load_ready.
- shift  in  1  consume the current element.
- out  out  DW  current element; '0 when empty.
- out_valid  out  1  buffer non-empty.
- row_done  out  1  one-cycle pulse on the cycle the last element (index N-1) of a row is consumed.
- full  out  1  count == BANKS.
- empty  out  1  count == 0.
- count  out  $clog2(BANKS+1)  number of rows resident, including a partially read row.
- overflow_err  out  1  sticky; present only with SYSARR_ROWBUF_ERR_EN.
- underflow_err  out  1  sticky; present only with SYSARR_ROWBUF_ERR_EN.

## Operation
- State:
  - wr_bank, rd_bank in 0..BANKS-1; both wrap BANKS-1 → 0.
  - rd_elem in 0..N-1.
  - count.
  - mem[BANKS][N] of DW bits.
- Load accept (load && !full): write all N elements into mem[wr_bank]; wr_bank advances; count +1.
- Shift accept (shift && !empty):
  - If rd_elem < N-1: rd_elem +1.
  - If rd_elem == N-1: rd_elem → 0, rd_bank advances, count −1, row_done = 1.
- Combinational outputs:
  - out = empty ? '0 : mem[rd_bank][rd_elem].
  - out_valid = !empty; load_ready = !full.
- Ignored requests: load while full and shift while empty are dropped with no state change.
- Load and shift in the same cycle:
  - Both are evaluated against the current count. There is no bypass, so a load into an empty buffer cannot be read that cycle.
  - When both are accepted and the shift retires a row, count is unchanged.
  - When full, a load is refused even if the same cycle's shift retires a row.
- flush has priority over load and shift in the same cycle:
  - Pointers and count clear; row_done stays 0.
  - mem is not cleared; stale data is unreachable because count is 0.
- Reset:
  - Pointers, count and error flags clear; mem is not reset.
  - Outputs after reset: out='0, out_valid=0, load_ready=1, full=0, empty=1, count=0, row_done=0.
  - RST asserted mid-row abandons that row. The next output is from the first row loaded after reset, starting at element 0.

## Timing
- Load → output latency is 1 cycle: a row accepted at edge k gives out_valid=1 and out=element 0 after edge k.
- Each accepted shift advances out at the next edge, so sustained throughput is 1 element/cycle.
- With BANKS ≥ 2, a new row can be loaded while the previous one streams, giving a gapless stream across rows.
- row_done is combinational from the accepted shift of element N-1. It is high in the same cycle as that shift, not registered.
- full, empty, count and load_ready change only at clock edges.

## Configuration
- SYSARR_ROWBUF_ERR_EN defined:
  - overflow_err sets on load && full.
  - underflow_err sets on shift && empty.
  - Both are sticky and cleared only by RST or flush; flush wins over a same-cycle set.
- SYSARR_ROWBUF_ERR_EN undefined: both ports and their registers are absent, and the same events are silently dropped.

## Structure
- sys_arr_pkg holds:
  - the DW and N defaults;
  - a row_t typedef (logic [N-1:0][DW-1:0]);
  - a ROWBUF_BANKS default constant.
- Sub-module sysarr_rowbuf_ptr:
  - parametrised modulo-M wrap counter with inc and clr;
  - instantiated for wr_bank (M=BANKS), rd_bank (M=BANKS) and rd_elem (M=N).
- The interface is extended with a new modport, or the block uses plain ports. The existing FIFO modport stays unchanged.

## Test plan
All scenarios use DW=16, N=4, BANKS=3.
- Reset then idle → empty=1, load_ready=1, count=0, out=0x0000, row_done=0.
- Load 0x0001_0002_0003_0004, then 4 shifts → out sequence 0x0001, 0x0002, 0x0003, 0x0004; row_done high on the 4th shift; empty=1 after it.
- Load 3 rows, attempt a 4th load → full=1, load_ready=0, 4th row dropped, count=3. With ERR_EN, overflow_err=1.
- Steady state: load a new row on the same cycle the last element of the current row is shifted → count unchanged, no bubble on out across the row boundary, bank pointer wraps 2→0.
- Shift while empty, then flush during a half-read row (rd_elem=2) → underflow_err=1 under ERR_EN. After flush: count=0, error flags 0, and the next loaded row reads from element 0.
- Assert RST mid-row → outputs return to their reset values the next cycle, and the following load streams correctly.

Source files
------------

// File: rtl/sys_arr_pkg.sv
// Shared systolic-array defaults: element width, row length and row-buffer depth.
package sys_arr_pkg;

    localparam int DW = 16;
    localparam int N  = 4;
    localparam int ROWBUF_BANKS = 2;

    typedef logic [N-1:0][DW-1:0] row_t;

endpackage

// File: rtl/sysarr_rowbuf_ptr.sv
// Modulo-M wrap counter used for the row buffer's bank and element pointers.
module sysarr_rowbuf_ptr #(
    parameter int M = 2,
    localparam int W = (M > 1) ? $clog2(M) : 1
) (
    input  logic         clk,
    input  logic         RST,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] LAST = W'(M - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    always_ff @(posedge clk) begin
        if (RST || clr) begin
            value <= '0;
        end else if (inc) begin
            value <= (value == LAST) ? '0 : value + ONE;
        end
    end

endmodule

// File: rtl/sysarr_row_buffer.sv
// Multi-bank row staging buffer: loads whole rows, streams one element per shift.
// Optional sticky overflow/underflow flags are built with SYSARR_ROWBUF_ERR_EN.
module sysarr_row_buffer
    import sys_arr_pkg::ROWBUF_BANKS;
#(
    parameter int DW    = sys_arr_pkg::DW,
    parameter int N     = sys_arr_pkg::N,
    parameter int BANKS = ROWBUF_BANKS
) (
    input  logic                       clk,
    input  logic                       RST,
    input  logic                       flush,
    input  logic                       load,
    input  logic [DW*N-1:0]            load_values,
    output logic                       load_ready,
    input  logic                       shift,
    output logic [DW-1:0]              out,
    output logic                       out_valid,
    output logic                       row_done,
    output logic                       full,
    output logic                       empty,
`ifdef SYSARR_ROWBUF_ERR_EN
    output logic                       overflow_err,
    output logic                       underflow_err,
`endif
    output logic [$clog2(BANKS+1)-1:0] count
);

    localparam int CW = $clog2(BANKS + 1);
    localparam int BW = $clog2(BANKS);
    localparam int EW = $clog2(N);

    localparam logic [CW-1:0] FULL_CNT  = CW'(BANKS);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [EW-1:0] LAST_ELEM = EW'(N - 1);

    logic [BW-1:0] wr_bank;
    logic [BW-1:0] rd_bank;
    logic [EW-1:0] rd_elem;
    logic [DW-1:0] mem [BANKS][N];

    logic load_acc;
    logic shift_acc;
    logic retire;

    // Flush and reset both outrank any same-cycle load or shift.
    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign load_ready = !full;
    assign out_valid  = !empty;
    assign load_acc   = load && !full && !flush && !RST;
    assign shift_acc  = shift && !empty && !flush && !RST;
    assign retire     = shift_acc && (rd_elem == LAST_ELEM);
    assign row_done   = retire;
    assign out        = empty ? '0 : mem[rd_bank][rd_elem];

    sysarr_rowbuf_ptr #(.M(BANKS)) u_wr_bank (
        .clk   (clk),
        .RST   (RST),
        .clr   (flush),
        .inc   (load_acc),
        .value (wr_bank)
    );

    sysarr_rowbuf_ptr #(.M(BANKS)) u_rd_bank (
        .clk   (clk),
        .RST   (RST),
        .clr   (flush),
        .inc   (retire),
        .value (rd_bank)
    );

    sysarr_rowbuf_ptr #(.M(N)) u_rd_elem (
        .clk   (clk),
        .RST   (RST),
        .clr   (flush),
        .inc   (shift_acc),
        .value (rd_elem)
    );

    // Element 0 sits in the MSB slice of load_values.
    always_ff @(posedge clk) begin
        if (load_acc) begin
            for (int i = 0; i < N; i++) begin
                mem[wr_bank][i] <= load_values[(N-1-i)*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RST || flush) begin
            count <= '0;
        end else if (load_acc && !retire) begin
            count <= count + CNT_ONE;
        end else if (retire && !load_acc) begin
            count <= count - CNT_ONE;
        end
    end

`ifdef SYSARR_ROWBUF_ERR_EN
    // Flags record the raw request against the current occupancy; flush wins.
    always_ff @(posedge clk) begin
        if (RST || flush) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (load && full) begin
                overflow_err <= 1'b1;
            end
            if (shift && empty) begin
                underflow_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sysarr_row_buffer.sv
// Directed self-checking bench for sysarr_row_buffer (DW=16, N=4, BANKS=3).
module tb_sysarr_row_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        load = 1'b0;
    logic [63:0] load_values = '0;
    logic        shift = 1'b0;
    logic        load_ready;
    logic [15:0] out;
    logic        out_valid;
    logic        row_done;
    logic        full;
    logic        empty;
    logic [1:0]  count;
`ifdef SYSARR_ROWBUF_ERR_EN
    logic        overflow_err;
    logic        underflow_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sysarr_row_buffer #(.DW(16), .N(4), .BANKS(3)) dut (
        .clk          (clk),
        .RST          (rst),
        .flush        (flush),
        .load         (load),
        .load_values  (load_values),
        .load_ready   (load_ready),
        .shift        (shift),
        .out          (out),
        .out_valid    (out_valid),
        .row_done     (row_done),
        .full         (full),
        .empty        (empty),
`ifdef SYSARR_ROWBUF_ERR_EN
        .overflow_err (overflow_err),
        .underflow_err(underflow_err),
`endif
        .count        (count)
    );

    function automatic logic [15:0] elem(input logic [63:0] row, input int i);
        return row[(3-i)*16 +: 16];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_row(input logic [63:0] row);
        load = 1'b1;
        load_values = row;
        cyc();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        checks++;
        if (empty !== 1'b1 || load_ready !== 1'b1 || count !== 2'd0 || out !== 16'h0000 ||
            row_done !== 1'b0 || out_valid !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: empty=%b ready=%b count=%0d out=%h done=%b valid=%b full=%b",
                     empty, load_ready, count, out, row_done, out_valid, full);
        end
    endtask

    task automatic test_single_row();
        logic [63:0] r = 64'h0001_0002_0003_0004;
        load_row(r);
        shift = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (out !== elem(r, i) || row_done !== (i == 3) || out_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL single_row[%0d]: out=%h done=%b valid=%b expected out=%h done=%b valid=1",
                         i, out, row_done, out_valid, elem(r, i), (i == 3));
            end
            cyc();
        end
        shift = 1'b0;
        #1;
        checks++;
        if (empty !== 1'b1 || count !== 2'd0 || row_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_row_drained: empty=%b count=%0d done=%b expected 1 0 0",
                     empty, count, row_done);
        end
    endtask

    task automatic test_full();
        logic [63:0] rows [3];
        rows[0] = 64'h1100_1101_1102_1103;
        rows[1] = 64'h2200_2201_2202_2203;
        rows[2] = 64'h3300_3301_3302_3303;
        load = 1'b1;
        for (int k = 0; k < 3; k++) begin
            load_values = rows[k];
            #1;
            checks++;
            if (load_ready !== 1'b1 || count !== 2'(k)) begin
                errors++;
                $display("[TB] FAIL fill[%0d]: ready=%b count=%0d expected ready=1 count=%0d",
                         k, load_ready, count, k);
            end
            cyc();
        end
        load_values = 64'hDEAD_BEEF_DEAD_BEEF;
        #1;
        checks++;
        if (load_ready !== 1'b0 || full !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_flags: ready=%b full=%b expected ready=0 full=1", load_ready, full);
        end
        cyc();
        load = 1'b0;
        #1;
        checks++;
        if (count !== 2'd3 || full !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overflow_dropped: count=%0d full=%b expected 3 1", count, full);
        end
`ifdef SYSARR_ROWBUF_ERR_EN
        checks++;
        if (overflow_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overflow_err: got %b expected 1", overflow_err);
        end
`endif
        shift = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) begin
                #1;
                checks++;
                if (out !== elem(rows[k], i) || row_done !== (i == 3)) begin
                    errors++;
                    $display("[TB] FAIL drain[%0d][%0d]: out=%h done=%b expected out=%h done=%b",
                             k, i, out, row_done, elem(rows[k], i), (i == 3));
                end
                cyc();
            end
        end
        shift = 1'b0;
        #1;
        checks++;
        if (empty !== 1'b1 || count !== 2'd0) begin
            errors++;
            $display("[TB] FAIL drain_empty: empty=%b count=%0d expected 1 0", empty, count);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] rows [3];
        rows[0] = 64'hA000_A001_A002_A003;
        rows[1] = 64'hB000_B001_B002_B003;
        rows[2] = 64'hC000_C001_C002_C003;
        load_row(rows[0]);
        shift = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (i == 3 && k < 2) begin
                    load = 1'b1;
                    load_values = rows[k+1];
                end
                #1;
                checks++;
                if (out !== elem(rows[k], i) || out_valid !== 1'b1 || row_done !== (i == 3) ||
                    count !== 2'd1) begin
                    errors++;
                    $display("[TB] FAIL stream[%0d][%0d]: out=%h valid=%b done=%b count=%0d expected out=%h valid=1 done=%b count=1",
                             k, i, out, out_valid, row_done, count, elem(rows[k], i), (i == 3));
                end
                cyc();
                load = 1'b0;
            end
        end
        shift = 1'b0;
        #1;
        checks++;
        if (empty !== 1'b1 || count !== 2'd0) begin
            errors++;
            $display("[TB] FAIL stream_empty: empty=%b count=%0d expected 1 0", empty, count);
        end
    endtask

    task automatic test_flush();
        logic [63:0] s = 64'h5000_5001_5002_5003;
        logic [63:0] t = 64'h6000_6001_6002_6003;
        shift = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || row_done !== 1'b0 || out !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL underflow_ignored: valid=%b done=%b out=%h expected 0 0 0000",
                     out_valid, row_done, out);
        end
        cyc();
        shift = 1'b0;
        #1;
        checks++;
        if (count !== 2'd0 || empty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL underflow_state: count=%0d empty=%b expected 0 1", count, empty);
        end
`ifdef SYSARR_ROWBUF_ERR_EN
        checks++;
        if (underflow_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL underflow_err: got %b expected 1", underflow_err);
        end
`endif
        load_row(s);
        shift = 1'b1;
        cyc();
        cyc();
        shift = 1'b0;
        #1;
        checks++;
        if (out !== elem(s, 2)) begin
            errors++;
            $display("[TB] FAIL half_read: out=%h expected %h", out, elem(s, 2));
        end
        flush = 1'b1;
        load = 1'b1;
        load_values = 64'hEEEE_EEEE_EEEE_EEEE;
        shift = 1'b1;
        cyc();
        flush = 1'b0;
        load = 1'b0;
        shift = 1'b0;
        #1;
        checks++;
        if (count !== 2'd0 || empty !== 1'b1 || out !== 16'h0000 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_flush: count=%0d empty=%b out=%h valid=%b expected 0 1 0000 0",
                     count, empty, out, out_valid);
        end
`ifdef SYSARR_ROWBUF_ERR_EN
        checks++;
        if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_err_clear: ovf=%b unf=%b expected 0 0", overflow_err, underflow_err);
        end
`endif
        load_row(t);
        shift = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (out !== elem(t, i) || row_done !== (i == 3)) begin
                errors++;
                $display("[TB] FAIL post_flush[%0d]: out=%h done=%b expected out=%h done=%b",
                         i, out, row_done, elem(t, i), (i == 3));
            end
            cyc();
        end
        shift = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [63:0] u = 64'h7000_7001_7002_7003;
        logic [63:0] v = 64'h8000_8001_8002_8003;
        load_row(u);
        shift = 1'b1;
        cyc();
        shift = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        checks++;
        if (empty !== 1'b1 || count !== 2'd0 || out !== 16'h0000 || load_ready !== 1'b1 ||
            out_valid !== 1'b0 || row_done !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_state: empty=%b count=%0d out=%h ready=%b valid=%b done=%b full=%b",
                     empty, count, out, load_ready, out_valid, row_done, full);
        end
        load_row(v);
        shift = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (out !== elem(v, i) || row_done !== (i == 3)) begin
                errors++;
                $display("[TB] FAIL post_reset[%0d]: out=%h done=%b expected out=%h done=%b",
                         i, out, row_done, elem(v, i), (i == 3));
            end
            cyc();
        end
        shift = 1'b0;
        #1;
        checks++;
        if (empty !== 1'b1 || count !== 2'd0) begin
            errors++;
            $display("[TB] FAIL post_reset_empty: empty=%b count=%0d expected 1 0", empty, count);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_single_row();
        test_full();
        test_back_to_back();
        test_flush();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
